// File: rtl/data_mem_fetch_ctrl.sv
// data_mem_fetch_ctrl: read sequencer for the dual-port 512-bit input data
// memory. It walks overlapping 4-row Winograd tiles and issues one row pair
// per cycle, gated by downstream credits. Sideband beat markers are delayed
// to line up with the memory's data-valid output.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   start                          job start pulse (accepted in IDLE, scan_enable low)
//   base_addr, row_stride          row 0 of tile 0, step between tile rows
//   num_tiles                      tiles to fetch (0 legal)
//   scan_enable                    memory scan-load in progress
//   credit_return                  downstream freed one row-pair slot
//   addr_1_out/addr_2_out          read addresses for ports 1/2
//   addr_1_valid_out/addr_2_valid_out  read requests for ports 1/2
//   beat_valid/beat_first/beat_last/tile_idx  sideband aligned with read data
//   busy, done, err                job status (err is sticky until next start)
module data_mem_fetch_ctrl #(
  parameter int unsigned MEM_DEPTH    = 128,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CREDIT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] base_addr,
  input  logic [7:0] row_stride,
  input  logic [7:0] num_tiles,
  input  logic       scan_enable,
  input  logic       credit_return,
  output logic [7:0] addr_1_out,
  output logic [7:0] addr_2_out,
  output logic       addr_1_valid_out,
  output logic       addr_2_valid_out,
  output logic       beat_valid,
  output logic       beat_first,
  output logic       beat_last,
  output logic [7:0] tile_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned AW  = 10;
  localparam int unsigned CW  = 4;
  localparam int unsigned SBW = 11;  // {valid, first, last, tile[7:0]}

  typedef enum logic [1:0] {IDLE, ROW01, ROW23, FIN} state_t;

  state_t          state;
  logic [AW-1:0]   tile_base;
  logic [7:0]      stride_q;
  logic [7:0]      num_q;
  logic [7:0]      tile_q;
  logic [CW-1:0]   credit;
  logic [SBW-1:0]  sb_q [0:READ_LATENCY];

  logic [AW-1:0]   stride1;
  logic [AW-1:0]   stride2;
  logic [AW-1:0]   a1;
  logic [AW-1:0]   a2;
  logic            can_go;
  logic            in_range;
  logic            issue;
  logic            abort;
  logic            last_tile;
  logic [SBW-1:0]  sb_in;

  // Candidate addresses for the current row pair, kept at 10 bits so that an
  // overflow past the 8-bit address space is still caught by the range check.
  always_comb begin
    stride1   = AW'(stride_q);
    stride2   = AW'({stride_q, 1'b0});
    a1        = tile_base;
    a2        = tile_base + stride1;
    if (state == ROW23) begin
      a1 = tile_base + stride2;
      a2 = tile_base + stride2 + stride1;
    end
    can_go    = ((state == ROW01) || (state == ROW23)) && (credit != '0);
    in_range  = (a1 < AW'(MEM_DEPTH)) && (a2 < AW'(MEM_DEPTH));
    issue     = can_go && in_range;
    abort     = can_go && !in_range;
    last_tile = (9'(tile_q) + 9'd1) >= 9'(num_q);
    sb_in     = '0;
    if (issue) begin
      sb_in = {1'b1, (state == ROW01), (state == ROW23) && last_tile, tile_q};
    end
  end

  // Sideband taps the end of the delay line; stage 0 is aligned with the valids.
  assign beat_valid = sb_q[READ_LATENCY][10];
  assign beat_first = sb_q[READ_LATENCY][9];
  assign beat_last  = sb_q[READ_LATENCY][8];
  assign tile_idx   = sb_q[READ_LATENCY][7:0];

  // Sequencer, credit counter, request registers and sideband pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      tile_base        <= '0;
      stride_q         <= '0;
      num_q            <= '0;
      tile_q           <= '0;
      credit           <= CW'(CREDIT_DEPTH);
      addr_1_out       <= '0;
      addr_2_out       <= '0;
      addr_1_valid_out <= 1'b0;
      addr_2_valid_out <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      for (int unsigned i = 0; i <= READ_LATENCY; i++) sb_q[i] <= '0;
    end else begin
      addr_1_valid_out <= issue;
      addr_2_valid_out <= issue;
      if (issue) begin
        addr_1_out <= 8'(a1);
        addr_2_out <= 8'(a2);
      end
      busy <= (state != IDLE);
      done <= (state == FIN);

      // Simultaneous issue and return cancel; returns saturate at full.
      if (issue && !credit_return) begin
        credit <= credit - CW'(1);
      end else if (!issue && credit_return && (credit < CW'(CREDIT_DEPTH))) begin
        credit <= credit + CW'(1);
      end

      sb_q[0] <= sb_in;
      for (int unsigned i = 1; i <= READ_LATENCY; i++) sb_q[i] <= sb_q[i-1];

      case (state)
        IDLE: begin
          if (start && !scan_enable) begin
            tile_base <= AW'(base_addr);
            stride_q  <= row_stride;
            num_q     <= num_tiles;
            tile_q    <= '0;
            err       <= 1'b0;
            state     <= (num_tiles == '0) ? FIN : ROW01;
          end
        end
        ROW01: begin
          if (abort) begin
            err   <= 1'b1;
            state <= FIN;
          end else if (issue) begin
            state <= ROW23;
          end
        end
        ROW23: begin
          if (abort) begin
            err   <= 1'b1;
            state <= FIN;
          end else if (issue) begin
            // Next tile starts on this tile's row 2 (two-row overlap).
            tile_base <= tile_base + stride2;
            if (last_tile) begin
              state <= FIN;
            end else begin
              tile_q <= tile_q + 8'd1;
              state  <= ROW01;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_fetch_ctrl.sv
// Testbench for data_mem_fetch_ctrl: directed scenarios plus randomized jobs,
// compared every cycle against a queue-based reference model.
module tb_data_mem_fetch_ctrl;

  localparam int RL    = 1;
  localparam int DEPTH = 4;
  localparam int MEMD  = 128;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] row_stride;
  logic [7:0] num_tiles;
  logic       scan_enable;
  logic       credit_return;
  logic [7:0] addr_1_out;
  logic [7:0] addr_2_out;
  logic       addr_1_valid_out;
  logic       addr_2_valid_out;
  logic       beat_valid;
  logic       beat_first;
  logic       beat_last;
  logic [7:0] tile_idx;
  logic       busy;
  logic       done;
  logic       err;

  data_mem_fetch_ctrl #(
    .MEM_DEPTH(MEMD), .READ_LATENCY(RL), .CREDIT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .row_stride(row_stride), .num_tiles(num_tiles), .scan_enable(scan_enable),
    .credit_return(credit_return), .addr_1_out(addr_1_out), .addr_2_out(addr_2_out),
    .addr_1_valid_out(addr_1_valid_out), .addr_2_valid_out(addr_2_valid_out),
    .beat_valid(beat_valid), .beat_first(beat_first), .beat_last(beat_last),
    .tile_idx(tile_idx), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a1;
    int a2;
    bit first;
    bit last;
    int idx;
  } pair_t;

  typedef struct packed {
    logic       v;
    logic       f;
    logic       l;
    logic [7:0] idx;
  } sb_t;

  int total = 0;
  int bad   = 0;

  // Reference model: the whole job is expanded into a queue of row pairs up
  // front; each credited cycle pops one pair.
  pair_t q[$];
  int    m_phase;   // 0 idle, 1 fetching, 2 finishing
  int    m_cred;
  bit    m_abort;
  bit    m_err;
  int    e_a1, e_a2;
  bit    e_v, e_busy, e_done;
  sb_t   hist [0:RL];
  int    issues_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build_job(input int base, input int s, input int n);
    int tb;
    pair_t p;
    q.delete();
    m_abort = 0;
    tb = base;
    for (int t = 0; t < n; t++) begin
      if (tb >= MEMD || tb + s >= MEMD) begin m_abort = 1; break; end
      p.a1 = tb; p.a2 = tb + s; p.first = 1; p.last = 0; p.idx = t;
      q.push_back(p);
      if (tb + 2*s >= MEMD || tb + 3*s >= MEMD) begin m_abort = 1; break; end
      p.a1 = tb + 2*s; p.a2 = tb + 3*s; p.first = 0; p.last = (t == n-1); p.idx = t;
      q.push_back(p);
      tb = tb + 2*s;
    end
  endtask

  task automatic model_edge();
    sb_t   nsb;
    bit    iss;
    int    ph;
    pair_t p;
    nsb = '0;
    iss = 0;
    ph  = m_phase;
    if (reset) begin
      m_phase = 0; m_cred = DEPTH; m_err = 0; m_abort = 0;
      e_a1 = 0; e_a2 = 0; e_v = 0; e_busy = 0; e_done = 0;
      q.delete();
      for (int i = 0; i <= RL; i++) hist[i] = '0;
      return;
    end
    e_busy = (ph != 0);
    e_done = (ph == 2);
    case (ph)
      0: if (start && !scan_enable) begin
           build_job(int'(base_addr), int'(row_stride), int'(num_tiles));
           m_err   = 0;
           m_phase = (num_tiles == 0) ? 2 : 1;
         end
      1: if (m_cred > 0) begin
           if (q.size() > 0) begin
             p = q.pop_front();
             iss = 1;
             e_a1 = p.a1; e_a2 = p.a2;
             nsb = {1'b1, p.first, p.last, 8'(p.idx)};
             if (q.size() == 0 && !m_abort) m_phase = 2;
           end else begin
             m_err = 1;
             m_phase = 2;
           end
         end
      default: m_phase = 0;
    endcase
    e_v = iss;
    if (iss) issues_seen++;
    if (iss && !credit_return) m_cred--;
    else if (!iss && credit_return && m_cred < DEPTH) m_cred++;
    for (int i = RL; i >= 1; i--) hist[i] = hist[i-1];
    hist[0] = nsb;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("addr_1_valid", 32'(addr_1_valid_out), 32'(e_v));
    check("addr_2_valid", 32'(addr_2_valid_out), 32'(e_v));
    check("addr_1", 32'(addr_1_out), 32'(e_a1));
    check("addr_2", 32'(addr_2_out), 32'(e_a2));
    check("beat_valid", 32'(beat_valid), 32'(hist[RL].v));
    check("beat_first", 32'(beat_first), 32'(hist[RL].f));
    check("beat_last", 32'(beat_last), 32'(hist[RL].l));
    check("tile_idx", 32'(tile_idx), 32'(hist[RL].idx));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic launch(input int base, input int s, input int n);
    base_addr = 8'(base); row_stride = 8'(s); num_tiles = 8'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs until the model is idle; ret_pct is the per-cycle credit_return odds.
  task automatic run_job(input int ret_pct, input int budget);
    int k;
    k = 0;
    while (m_phase != 0 && k < budget) begin
      credit_return = ($urandom_range(0, 99) < ret_pct);
      step();
      k++;
    end
    credit_return = 1'b0;
    if (m_phase != 0) check("job_timeout", 32'(m_phase), 32'd0);
    for (int i = 0; i < RL + 2; i++) step();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; base_addr = '0; row_stride = '0; num_tiles = '0;
    scan_enable = 1'b0; credit_return = 1'b0;
    issues_seen = 0;
    m_phase = 0; m_cred = DEPTH; m_err = 0; m_abort = 0;
    e_a1 = 0; e_a2 = 0; e_v = 0; e_busy = 0; e_done = 0;
    for (int i = 0; i <= RL; i++) hist[i] = '0;

    do_reset();

    // Basic 3-tile walk with credits always returned.
    launch(0, 1, 3);
    run_job(100, 50);

    // Credit starvation: 4 issues, stall, a single return buys one more.
    launch(0, 1, 4);
    issues_seen = 0;
    for (int i = 0; i < 10; i++) step();
    check("starved_issues", 32'(issues_seen), 32'd4);
    check("starved_busy", 32'(busy), 32'd1);
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("one_credit_issue", 32'(issues_seen), 32'd5);
    run_job(100, 50);

    // Range abort on tile 1 row 2/3.
    issues_seen = 0;
    launch(120, 2, 2);
    run_job(100, 50);
    check("abort_issues", 32'(issues_seen), 32'd3);
    check("abort_err", 32'(err), 32'd1);

    // Zero-tile job, then an immediate follow-up job.
    launch(0, 3, 0);
    run_job(100, 10);
    launch(10, 3, 1);
    run_job(100, 20);

    // Start during scan-load is ignored.
    scan_enable = 1'b1;
    launch(0, 1, 2);
    scan_enable = 1'b0;
    step();
    check("scan_ignored_busy", 32'(busy), 32'd0);

    // Mid-job reset after 3 issues.
    issues_seen = 0;
    launch(5, 4, 5);
    for (int i = 0; i < 3; i++) step();
    check("pre_reset_issues", 32'(issues_seen), 32'd3);
    do_reset();
    issues_seen = 0;
    launch(0, 1, 4);
    for (int i = 0; i < 8; i++) step();
    check("credits_restored", 32'(issues_seen), 32'd4);
    run_job(100, 50);

    // Randomized jobs with random returns, scan-load, stray starts and resets.
    for (int j = 0; j < 40; j++) begin
      scan_enable = ($urandom_range(0, 9) == 0);
      launch($urandom_range(0, 130), $urandom_range(0, 40), $urandom_range(0, 6));
      scan_enable = 1'b0;
      for (int k = 0; k < 300 && m_phase != 0; k++) begin
        credit_return = ($urandom_range(0, 99) < 55);
        scan_enable   = ($urandom_range(0, 9) == 0);
        start         = ($urandom_range(0, 19) == 0);
        reset         = ($urandom_range(0, 99) < 2);
        step();
      end
      reset = 1'b0; start = 1'b0; scan_enable = 1'b0; credit_return = 1'b0;
      if (m_phase != 0) check("rand_timeout", 32'(m_phase), 32'd0);
      for (int i = 0; i < RL + 2; i++) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_fetch_ctrl.md
Name: data_mem_fetch_ctrl

Overview:
Read sequencer for the dual-port 512-bit input data memory. It walks overlapping 4-row Winograd input tiles and drives both memory read ports, one row pair per cycle. It applies credit-based backpressure from the downstream tile buffer and emits sideband markers aligned with the memory's data-valid outputs. It locks out fetches while the memory is being scan-loaded.

Parameters:
MEM_DEPTH, 128, number of valid memory rows; any issued address must be < MEM_DEPTH
READ_LATENCY, 1, cycles from addr_valid to memory data_valid; sideband delay, range 1..4
CREDIT_DEPTH, 4, row-pair slots in the downstream buffer; range 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a job when IDLE and scan_enable low
base_addr  in  8  row address of row 0 of tile 0
row_stride  in  8  address step between consecutive rows of a tile
num_tiles  in  8  tiles to fetch; 0 is legal
scan_enable  in  1  memory scan-load in progress
credit_return  in  1  downstream freed one row-pair slot
addr_1_out  out  8  port-1 read address
addr_2_out  out  8  port-2 read address
addr_1_valid_out  out  1  port-1 read request
addr_2_valid_out  out  1  port-2 read request
beat_valid  out  1  sideband valid, aligned with memory data_valid
beat_first  out  1  aligned beat carries rows 0/1 of a tile
beat_last  out  1  aligned beat is rows 2/3 of the final tile
tile_idx  out  8  tile index of the aligned beat
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
err  out  1  sticky; set when a job aborts on an out-of-range address

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; credit count = CREDIT_DEPTH; sideband pipe cleared; err cleared. Reset mid-job abandons the job with no done pulse.
- start is accepted only in IDLE with scan_enable=0; otherwise it is ignored. On accept, latch base_addr, row_stride and num_tiles, clear err, set tile=0 and tile_base=base_addr.
- FSM states: IDLE, ROW01, ROW23, FIN.
  - IDLE -> ROW01 on accepted start with num_tiles≠0.
  - IDLE -> FIN on accepted start with num_tiles=0.
  - ROW01 -> ROW23 on issue.
  - ROW23 -> ROW01 on issue when tile+1<num_tiles; -> FIN on issue of the last tile.
  - FIN -> IDLE after one cycle; done=1 in FIN.
- Issue condition: state ∈ {ROW01, ROW23} and credit count > 0. When the condition is false, both valids stay 0 and the addresses hold their values.
- An issue drives both valids high for one cycle:
  - ROW01: addr_1 = tile_base, addr_2 = tile_base + stride.
  - ROW23: addr_1 = tile_base + 2·stride, addr_2 = tile_base + 3·stride.
- Addresses are computed at 10 bits; no wrap. After a ROW23 issue, tile_base += 2·stride (two-row overlap between tiles).
- Range check: if either address ≥ MEM_DEPTH, no issue occurs. Instead set err=1 and go to FIN (done still pulses). Beats already issued drain normally.
- Credits: −1 on issue, +1 on credit_return. Simultaneous issue and return leaves the count unchanged. A return while at CREDIT_DEPTH saturates (count stays at CREDIT_DEPTH).
- Sideband: {first, last, tile_idx} is captured at issue and delayed READ_LATENCY cycles; beat_valid = the delayed issue.
- busy=1 in ROW01, ROW23 and FIN.
- If scan_enable rises mid-job, the job continues; the scan/controller exclusion is the top level's responsibility.

Test Plan:
- base=0, stride=1, num_tiles=3, credits free -> issues (0,1),(2,3),(2,3),(4,5),(4,5),(6,7) on 6 consecutive cycles; done 1 cycle after last issue; beat_first on beats 1,3,5; beat_last on beat 6 only, each READ_LATENCY after issue.
- CREDIT_DEPTH=4, no credit_return, num_tiles=4 -> exactly 4 issues, then valids low and busy=1; one credit_return pulse -> exactly one more issue next cycle.
- base=120, stride=2, num_tiles=2 -> tile 0 issues (120,122),(124,126); tile 1 ROW01 would give 124,126 (legal) and ROW23 would give 128 -> no issue, err=1, done pulse, 3 beats total.
- num_tiles=0 start -> no valids; busy and done high for 1 cycle; next start accepted.
- start with scan_enable=1 -> ignored, busy stays 0; reset asserted mid-job after 3 issues -> next cycle all outputs 0, no done, credit count restored to 4.
